// File: rtl/dp_operand_sequencer_if.sv
// Operand-sequencer bus: decoder-side instruction handshake, register-bank read
// port, and the ALU bundle handshake.
interface dp_operand_sequencer_if;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        instr_valid;
  logic        instr_ready;
  logic        flush;
  logic        rf_req;
  logic [3:0]  rf_addr;
  logic        rf_gnt;
  logic [31:0] rf_rdata;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [7:0]  shamt;
  logic [1:0]  shtype;
  logic [3:0]  opcode;
  logic [3:0]  rd_addr;
  logic        set_cc;
  logic        out_valid;
  logic        out_ready;
  logic        seq_err;

  // master: the sequencer; slave: decoder, register bank and ALU around it
  modport master (
    input  instr, pc_in, instr_valid, flush, rf_gnt, rf_rdata, out_ready,
    output instr_ready, rf_req, rf_addr, op1, op2, shamt, shtype, opcode,
           rd_addr, set_cc, out_valid, seq_err
  );
  modport slave (
    output instr, pc_in, instr_valid, flush, rf_gnt, rf_rdata, out_ready,
    input  instr_ready, rf_req, rf_addr, op1, op2, shamt, shtype, opcode,
           rd_addr, set_cc, out_valid, seq_err
  );
endinterface

// File: rtl/dp_operand_sequencer.sv
// Fetches Rn/Rm/Rs for one ARM data-processing instruction through a shared
// register-bank read port and hands a complete operand bundle to the ALU.
module dp_operand_sequencer #(
    parameter logic [31:0] PC_OFFSET   = 32'd8,
    parameter int          GNT_TIMEOUT = 15
) (
    input logic clk,
    input logic rst,
    dp_operand_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD_RN, RD_RM, RD_RS, ISSUE} state_t;

    state_t      state, state_nxt;
    logic [31:0] ir, pc_q, word, rd_val;
    logic [31:0] op1, op2;
    logic [7:0]  shamt;
    logic [1:0]  shtype;
    logic [3:0]  tcnt, rf_addr, rf_addr_d;
    logic        rf_req, rf_req_d, out_valid, out_valid_d, seq_err, seq_err_d;
    logic        accept, in_read, cap, tmo;
    logic [2:0]  need;  // {rs, rm, rn}
    logic        unused_ir;

    function automatic state_t after(input state_t s, input logic [2:0] n);
        state_t r;
        r = ISSUE;
        case (s)
            IDLE:    r = n[0] ? RD_RN : n[1] ? RD_RM : n[2] ? RD_RS : ISSUE;
            RD_RN:   r = n[1] ? RD_RM : n[2] ? RD_RS : ISSUE;
            RD_RM:   r = n[2] ? RD_RS : ISSUE;
            default: r = ISSUE;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] addr_of(input state_t s, input logic [31:0] w);
        logic [3:0] a;
        a = 4'd0;
        case (s)
            RD_RN:   a = w[19:16];
            RD_RM:   a = w[3:0];
            RD_RS:   a = w[11:8];
            default: a = 4'd0;
        endcase
        return a;
    endfunction

    // Fields come straight from the input bus in the accept cycle, from ir afterwards
    assign word    = (state == IDLE) ? bus.instr : ir;
    assign need    = {~word[25] & word[4], ~word[25],
                      ~((word[24:21] == 4'hD) || (word[24:21] == 4'hF))};
    assign accept  = bus.instr_valid && (state == IDLE);
    assign in_read = (state == RD_RN) || (state == RD_RM) || (state == RD_RS);
    // rf_req low in a read state means the operand is R15: no bank access needed
    assign cap     = in_read && !bus.flush && (!rf_req || bus.rf_gnt);
    assign tmo     = in_read && rf_req && !bus.rf_gnt && (tcnt == 4'(GNT_TIMEOUT - 1));
    assign rd_val  = rf_req ? bus.rf_rdata : pc_q + PC_OFFSET;

    always_comb begin
        state_nxt = state;
        seq_err_d = 1'b0;
        case (state)
            IDLE:
                if (accept) begin
                    if (bus.instr[27:26] != 2'b00) seq_err_d = 1'b1;
                    else                           state_nxt = after(IDLE, need);
                end
            RD_RN, RD_RM, RD_RS:
                if (bus.flush)  state_nxt = IDLE;
                else if (cap)   state_nxt = after(state, need);
                else if (tmo) begin
                    state_nxt = IDLE;
                    seq_err_d = 1'b1;
                end
            ISSUE:
                if (bus.flush || bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        rf_addr_d   = addr_of(state_nxt, word);
        rf_req_d    = (state_nxt inside {RD_RN, RD_RM, RD_RS}) && (rf_addr_d != 4'hF);
        out_valid_d = (state_nxt == ISSUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ir        <= '0;
            pc_q      <= '0;
            tcnt      <= '0;
            rf_req    <= 1'b0;
            rf_addr   <= '0;
            out_valid <= 1'b0;
            seq_err   <= 1'b0;
            op1       <= '0;
            op2       <= '0;
            shamt     <= '0;
            shtype    <= '0;
        end else begin
            state     <= state_nxt;
            rf_req    <= rf_req_d;
            rf_addr   <= rf_addr_d;
            out_valid <= out_valid_d;
            seq_err   <= seq_err_d;
            tcnt      <= (state_nxt != state || !rf_req || bus.rf_gnt) ? 4'd0 : tcnt + 4'd1;
            if (accept) begin
                // Immediate/skip defaults; register reads overwrite them later
                ir     <= bus.instr;
                pc_q   <= bus.pc_in;
                op1    <= '0;
                op2    <= {24'b0, bus.instr[7:0]};
                shamt  <= bus.instr[25] ? {3'b0, bus.instr[11:8], 1'b0} : {3'b0, bus.instr[11:7]};
                shtype <= bus.instr[25] ? 2'b11 : bus.instr[6:5];
            end
            if (cap) begin
                case (state)
                    RD_RN:   op1   <= rd_val;
                    RD_RM:   op2   <= rd_val;
                    RD_RS:   shamt <= rd_val[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign unused_ir       = ^{ir[31:26], ir[7:5]};
    assign bus.instr_ready = (state == IDLE);
    assign bus.rf_req      = rf_req;
    assign bus.rf_addr     = rf_addr;
    assign bus.op1         = op1;
    assign bus.op2         = op2;
    assign bus.shamt       = shamt;
    assign bus.shtype      = shtype;
    assign bus.opcode      = ir[24:21];
    assign bus.rd_addr     = ir[15:12];
    assign bus.set_cc      = ir[20];
    assign bus.out_valid   = out_valid;
    assign bus.seq_err     = seq_err;
endmodule

// File: tb/tb_dp_operand_sequencer.sv
// Directed bench for dp_operand_sequencer: register/immediate/reg-shift forms,
// R15 substitution, grant timeout, backpressure, flush and async reset.
module tb_dp_operand_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] regs [16];

    dp_operand_sequencer_if bus();
    dp_operand_sequencer #(.PC_OFFSET(32'd8), .GNT_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;
    assign bus.rf_rdata = regs[bus.rf_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for exactly one accept edge
    task automatic issue(input logic [31:0] w, input logic [31:0] pc);
        bus.instr = w; bus.pc_in = pc; bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'hA000_0000 + i;
        regs[2] = 32'h22; regs[3] = 32'h33; regs[4] = 32'h105;
        bus.instr = '0; bus.pc_in = '0; bus.instr_valid = 1'b0; bus.flush = 1'b0;
        bus.rf_gnt = 1'b1; bus.out_ready = 1'b1;
        #12;
        chk("rst_ready", 32'(bus.instr_ready), 32'd1);
        chk("rst_req",   32'(bus.rf_req),      32'd0);
        chk("rst_valid", 32'(bus.out_valid),   32'd0);
        chk("rst_err",   32'(bus.seq_err),     32'd0);
        chk("rst_op1",   bus.op1,              32'd0);
        rst = 1'b0;
        step();

        // ADD R1,R2,R3 LSL #4
        issue(32'hE0821203, 32'h40);
        chk("add_rn_req",  32'(bus.rf_req),      32'd1);
        chk("add_rn_addr", 32'(bus.rf_addr),     32'd2);
        chk("add_busy",    32'(bus.instr_ready), 32'd0);
        step();
        chk("add_rm_addr", 32'(bus.rf_addr),     32'd3);
        chk("add_nv",      32'(bus.out_valid),   32'd0);
        step();
        chk("add_valid",  32'(bus.out_valid), 32'd1);
        chk("add_op1",    bus.op1,            32'h22);
        chk("add_op2",    bus.op2,            32'h33);
        chk("add_shamt",  32'(bus.shamt),     32'd4);
        chk("add_shtype", 32'(bus.shtype),    32'd0);
        chk("add_opcode", 32'(bus.opcode),    32'd4);
        chk("add_rd",     32'(bus.rd_addr),   32'd1);
        chk("add_req_off", 32'(bus.rf_req),   32'd0);
        step();
        chk("add_done_valid", 32'(bus.out_valid),   32'd0);
        chk("add_done_ready", 32'(bus.instr_ready), 32'd1);

        // MOV R0,#0xFF ROR 8
        issue(32'hE3A004FF, 32'h44);
        chk("mov_req",    32'(bus.rf_req),    32'd0);
        chk("mov_valid",  32'(bus.out_valid), 32'd1);
        chk("mov_op1",    bus.op1,            32'd0);
        chk("mov_op2",    bus.op2,            32'hFF);
        chk("mov_shamt",  32'(bus.shamt),     32'd8);
        chk("mov_shtype", 32'(bus.shtype),    32'd3);
        chk("mov_opcode", 32'(bus.opcode),    32'hD);
        step();

        // ADD R1,R2,R3,LSL R4
        issue(32'hE0821413, 32'h48);
        chk("rs_a0", 32'(bus.rf_addr), 32'd2);
        step();
        chk("rs_a1", 32'(bus.rf_addr), 32'd3);
        step();
        chk("rs_a2", 32'(bus.rf_addr), 32'd4);
        chk("rs_a2_req", 32'(bus.rf_req), 32'd1);
        step();
        chk("rs_valid", 32'(bus.out_valid), 32'd1);
        chk("rs_shamt", 32'(bus.shamt),     32'h05);
        chk("rs_op1",   bus.op1,            32'h22);
        chk("rs_op2",   bus.op2,            32'h33);
        step();

        // ADD R1,R15,#1 with pc 0x100
        issue(32'hE28F1001, 32'h100);
        chk("pc_noreq", 32'(bus.rf_req), 32'd0);
        step();
        chk("pc_valid", 32'(bus.out_valid), 32'd1);
        chk("pc_op1",   bus.op1,            32'h108);
        chk("pc_op2",   bus.op2,            32'h1);
        step();

        // Grant starvation: 15 cycles without grant aborts the instruction
        bus.rf_gnt = 1'b0;
        issue(32'hE0821203, 32'h50);
        for (int i = 0; i < 14; i++) step();
        chk("tmo_still_req", 32'(bus.rf_req),  32'd1);
        chk("tmo_no_err",    32'(bus.seq_err), 32'd0);
        step();
        chk("tmo_err",   32'(bus.seq_err),     32'd1);
        chk("tmo_ready", 32'(bus.instr_ready), 32'd1);
        chk("tmo_req",   32'(bus.rf_req),      32'd0);
        bus.rf_gnt = 1'b1;
        step();
        chk("tmo_pulse_end", 32'(bus.seq_err), 32'd0);
        issue(32'hE0821203, 32'h54);
        step();
        step();
        chk("tmo_next_valid", 32'(bus.out_valid), 32'd1);
        chk("tmo_next_op2",   bus.op2,            32'h33);
        step();

        // Backpressure: bundle held while out_ready is low
        bus.out_ready = 1'b0;
        issue(32'hE0821203, 32'h58);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_op1",   bus.op1,            32'h22);
            step();
        end
        chk("bp_shamt", 32'(bus.shamt), 32'd4);
        bus.out_ready = 1'b1;
        step();
        chk("bp_release", 32'(bus.out_valid), 32'd0);

        // Flush while reading Rm
        issue(32'hE0821203, 32'h5C);
        step();
        chk("fl_rm_addr", 32'(bus.rf_addr), 32'd3);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("fl_req",   32'(bus.rf_req),      32'd0);
        chk("fl_valid", 32'(bus.out_valid),   32'd0);
        chk("fl_ready", 32'(bus.instr_ready), 32'd1);
        chk("fl_err",   32'(bus.seq_err),     32'd0);

        // Async reset while reading Rs
        issue(32'hE0821413, 32'h60);
        step();
        step();
        chk("rr_rs_addr", 32'(bus.rf_addr), 32'd4);
        #2 rst = 1'b1;
        #1;
        chk("rr_req",   32'(bus.rf_req),      32'd0);
        chk("rr_ready", 32'(bus.instr_ready), 32'd1);
        chk("rr_op1",   bus.op1,              32'd0);
        step();
        rst = 1'b0;
        step();

        // Non data-processing class (LDR) is rejected
        issue(32'hE5912000, 32'h64);
        chk("ill_err",   32'(bus.seq_err),     32'd1);
        chk("ill_ready", 32'(bus.instr_ready), 32'd1);
        chk("ill_req",   32'(bus.rf_req),      32'd0);
        step();
        chk("ill_pulse_end", 32'(bus.seq_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
